traffic_light_ctrl: RTL and testbench
=====================================

# traffic_light_ctrl

Parametrised two-road (main/sub) traffic-light controller: a runtime sequencer that replaces the fixed power-on initialisation of lights, displays and remaining times. It walks a four-phase green/yellow/red cycle driven by a 1 Hz tick derived from the system clock. It supports run, pause and flashing-yellow ("online") modes, and drives the per-road light state, colour code and countdown display consumed by the seven-segment and LED drivers.

## Interface
- `CLOCK_HZ`, 5: system clock cycles per 1 s tick, ≥1.
- `MAIN_GREEN_T`, 16: main-road green duration in seconds.
- `SUB_GREEN_T`, 16: sub-road green duration in seconds.
- `YELLOW_T`, 3: yellow duration in seconds, both roads, ≥1.
- `TIME_W`, 5: countdown width; must hold max(MAIN_GREEN_T, SUB_GREEN_T) + YELLOW_T.
- Port list:
  - `clk` in 1: system clock.
  - `rst` in 1: synchronous, active-high reset.
  - `mode` in 2: 0 RUN, 1 PAUSE, 2 ONLINE (flash), 3 treated as PAUSE.
  - `source_en` in 1: lamp power enable.
  - `Source` out 1: registered copy of `source_en`.
  - `main_light_state`, `sub_light_state` out 3: RED=0, GREEN=1, YELLOW=2, ONLINE=3, PAUSE=4.
  - `MainColor`, `SubColor` out 8: OFF=0, RED=1, GREEN=2, YELLOW=3, ONLINE=4.
  - `main_rest_time`, `sub_rest_time` out TIME_W: seconds remaining in the current light.
  - `MainTime`, `SubTime` out 16: `*_rest_time` zero-extended, for the display.

## Operation
- Reset values:
  - phase MG_SR, `Source`=1.
  - `main_light_state`=GREEN, `sub_light_state`=RED.
  - `MainColor`=2, `SubColor`=1.
  - `main_rest_time`=MAIN_GREEN_T, `sub_rest_time`=MAIN_GREEN_T+YELLOW_T.
  - Display outputs follow; prescaler=0.
- Phase FSM: MG_SR → MY_SR → MR_SG → MR_SY → MG_SR.
- Loads on phase entry:
  - MG_SR: main=MAIN_GREEN_T, sub=MAIN_GREEN_T+YELLOW_T.
  - MY_SR: main=YELLOW_T; sub keeps counting.
  - MR_SG: main=SUB_GREEN_T+YELLOW_T, sub=SUB_GREEN_T.
  - MR_SY: sub=YELLOW_T; main keeps counting.
- RUN, on each tick:
  - If the counter of the road currently green/yellow equals 1, advance the phase and load per the table above.
  - Otherwise decrement both counters.
  - Counters never reach 0 in RUN.
- PAUSE:
  - Prescaler, counters and phase frozen.
  - Both light states = PAUSE; colours hold their last RUN value.
  - Returning to RUN resumes exactly where it stopped.
- ONLINE:
  - Both light states = ONLINE; both rest times = 0.
  - The prescaler keeps running; both colours toggle ONLINE(4)/OFF(0) each tick, starting at ONLINE on entry.
  - Leaving ONLINE for RUN restarts at MG_SR with full loads and prescaler cleared.
  - Leaving ONLINE for PAUSE freezes in the reset-equivalent MG_SR values.
- `source_en`=0: colours forced to OFF; the FSM is unaffected.
- Mode change and tick in the same cycle: the new mode wins and the tick is discarded.

## Timing
- Tick: one-cycle pulse when the prescaler counter reaches CLOCK_HZ−1. The counter then wraps to 0.
- Outputs are registered and update the cycle after the tick or mode change.
- `Source` lags `source_en` by one cycle.
- RUN cycle period, in ticks: MAIN_GREEN_T + SUB_GREEN_T + 2·YELLOW_T (38 at defaults).
- Reset asserted mid-cycle returns to reset values on the next edge, in any mode.

## Structure
- Package `traffic_pkg` holds:
  - the light-state codes;
  - the colour codes;
  - the mode encoding;
  - the phase enum (MG_SR, MY_SR, MR_SG, MR_SY).
- Sub-module `tick_prescaler` has parameter CLOCK_HZ and ports `clk`, `rst`, `en`, `clr`, `tick`.
- Top contains the phase FSM, two countdown registers and the output decode.

## Test plan
- Reset with defaults → MainColor=2, SubColor=1, main/sub rest=16/19, Source=1.
- RUN with CLOCK_HZ=2, MAIN_GREEN_T=4, SUB_GREEN_T=3, YELLOW_T=2:
  - main rest sequence 4,3,2,1,2,1,5,4,3,2,1 across phases;
  - phase returns to MG_SR after 11 ticks (22 clocks).
- PAUSE held for 10 clocks mid-MY_SR → outputs frozen, states=4; after RUN, countdown resumes from the same value.
- ONLINE for 4 ticks → colours 4,0,4,0 and rest times 0; then RUN → MG_SR with full loads.
- `rst` pulsed during MR_SG in ONLINE → next cycle shows reset values.
- `source_en`=0 during RUN → colours 0 while rest times keep counting; re-enable restores the phase colours.

Source files
------------

// File: rtl/traffic_pkg.sv
// traffic_pkg
// Shared encodings for the two-road traffic-light controller: per-road light
// state codes, lamp colour codes, mode encoding and the phase enum, plus
// small decode helpers used by the controller's output stage.
package traffic_pkg;

  localparam logic [2:0] LS_RED    = 3'd0;
  localparam logic [2:0] LS_GREEN  = 3'd1;
  localparam logic [2:0] LS_YELLOW = 3'd2;
  localparam logic [2:0] LS_ONLINE = 3'd3;
  localparam logic [2:0] LS_PAUSE  = 3'd4;

  localparam logic [7:0] COL_OFF    = 8'd0;
  localparam logic [7:0] COL_RED    = 8'd1;
  localparam logic [7:0] COL_GREEN  = 8'd2;
  localparam logic [7:0] COL_YELLOW = 8'd3;
  localparam logic [7:0] COL_ONLINE = 8'd4;

  localparam logic [1:0] MODE_RUN    = 2'd0;
  localparam logic [1:0] MODE_PAUSE  = 2'd1;
  localparam logic [1:0] MODE_ONLINE = 2'd2;

  typedef enum logic [1:0] {
    MG_SR = 2'd0,
    MY_SR = 2'd1,
    MR_SG = 2'd2,
    MR_SY = 2'd3
  } phase_t;

  // Code 3 is not a mode of its own; it behaves exactly like PAUSE.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return (m == 2'd3) ? MODE_PAUSE : m;
  endfunction

  function automatic logic [2:0] main_state(input phase_t p);
    case (p)
      MG_SR:   return LS_GREEN;
      MY_SR:   return LS_YELLOW;
      default: return LS_RED;
    endcase
  endfunction

  function automatic logic [2:0] sub_state(input phase_t p);
    case (p)
      MR_SG:   return LS_GREEN;
      MR_SY:   return LS_YELLOW;
      default: return LS_RED;
    endcase
  endfunction

  function automatic logic [7:0] state_color(input logic [2:0] s);
    case (s)
      LS_RED:    return COL_RED;
      LS_GREEN:  return COL_GREEN;
      LS_YELLOW: return COL_YELLOW;
      default:   return COL_OFF;
    endcase
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler
// Divides clk down to a one-cycle tick every CLOCK_HZ enabled cycles.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset, counter to 0
//   en   - count enable; while low the counter holds and no tick is issued
//   clr  - synchronous clear of the counter
//   tick - high for the enabled cycle in which the counter sits at CLOCK_HZ-1
module tick_prescaler #(
  parameter int CLOCK_HZ = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLOCK_HZ > 1) ? $clog2(CLOCK_HZ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLOCK_HZ - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl
// Two-road (main/sub) traffic-light sequencer with run, pause and flashing
// (online) modes, driving light state, colour code and countdown per road.
// Ports:
//   clk, rst                      - system clock, synchronous active-high reset
//   mode[1:0]                     - 0 RUN, 1 PAUSE, 2 ONLINE, 3 as PAUSE
//   source_en / Source            - lamp power enable / its registered copy
//   main_light_state, sub_light_state [2:0] - RED/GREEN/YELLOW/ONLINE/PAUSE
//   MainColor, SubColor [7:0]     - OFF/RED/GREEN/YELLOW/ONLINE colour code
//   main_rest_time, sub_rest_time - seconds left in the current light
//   MainTime, SubTime [15:0]      - rest times zero-extended for the display
//
// Phase FSM:
//   state | meaning
//   MG_SR | main green,  sub red
//   MY_SR | main yellow, sub red
//   MR_SG | main red,    sub green
//   MR_SY | main red,    sub yellow
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int CLOCK_HZ     = 5,
  parameter int MAIN_GREEN_T = 16,
  parameter int SUB_GREEN_T  = 16,
  parameter int YELLOW_T     = 3,
  parameter int TIME_W       = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic              source_en,
  output logic              Source,
  output logic [2:0]        main_light_state,
  output logic [2:0]        sub_light_state,
  output logic [7:0]        MainColor,
  output logic [7:0]        SubColor,
  output logic [TIME_W-1:0] main_rest_time,
  output logic [TIME_W-1:0] sub_rest_time,
  output logic [15:0]       MainTime,
  output logic [15:0]       SubTime
);

  localparam logic [TIME_W-1:0] LD_MG_MAIN = TIME_W'(MAIN_GREEN_T);
  localparam logic [TIME_W-1:0] LD_MG_SUB  = TIME_W'(MAIN_GREEN_T + YELLOW_T);
  localparam logic [TIME_W-1:0] LD_MR_MAIN = TIME_W'(SUB_GREEN_T + YELLOW_T);
  localparam logic [TIME_W-1:0] LD_MR_SUB  = TIME_W'(SUB_GREEN_T);
  localparam logic [TIME_W-1:0] LD_YELLOW  = TIME_W'(YELLOW_T);

  phase_t            phase, phase_nx;
  logic [TIME_W-1:0] main_cnt, main_nx;
  logic [TIME_W-1:0] sub_cnt, sub_nx;
  logic              flash, flash_nx;
  logic [1:0]        mode_q;
  logic [1:0]        mode_n;
  logic              mode_chg;
  logic              leave_online;
  logic              tick;
  logic              active_one;

  assign mode_n       = norm_mode(mode);
  assign mode_chg     = (mode_n != mode_q);
  assign leave_online = mode_chg && (mode_q == MODE_ONLINE);

  // Holding the prescaler on the mode-change cycle both discards a
  // coincident tick and lets PAUSE->RUN resume on the exact cycle count.
  tick_prescaler #(
    .CLOCK_HZ(CLOCK_HZ)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .en  ((mode_n != MODE_PAUSE) && !mode_chg),
    .clr (leave_online),
    .tick(tick)
  );

  // The road currently showing green/yellow owns the phase boundary.
  assign active_one = (phase == MG_SR || phase == MY_SR) ? (main_cnt == TIME_W'(1))
                                                         : (sub_cnt == TIME_W'(1));

  always_comb begin
    phase_nx = phase;
    main_nx  = main_cnt;
    sub_nx   = sub_cnt;
    flash_nx = flash;

    if (leave_online) begin
      phase_nx = MG_SR;
      main_nx  = LD_MG_MAIN;
      sub_nx   = LD_MG_SUB;
    end

    if (mode_n == MODE_ONLINE) begin
      if (mode_chg) begin
        flash_nx = 1'b1;
      end else if (tick) begin
        flash_nx = ~flash;
      end
    end else if (mode_n == MODE_RUN && tick) begin
      if (active_one) begin
        case (phase)
          MG_SR: begin
            phase_nx = MY_SR;
            main_nx  = LD_YELLOW;
            sub_nx   = sub_cnt - 1'b1;
          end
          MY_SR: begin
            phase_nx = MR_SG;
            main_nx  = LD_MR_MAIN;
            sub_nx   = LD_MR_SUB;
          end
          MR_SG: begin
            phase_nx = MR_SY;
            main_nx  = main_cnt - 1'b1;
            sub_nx   = LD_YELLOW;
          end
          default: begin
            phase_nx = MG_SR;
            main_nx  = LD_MG_MAIN;
            sub_nx   = LD_MG_SUB;
          end
        endcase
      end else begin
        main_nx = main_cnt - 1'b1;
        sub_nx  = sub_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase            <= MG_SR;
      main_cnt         <= LD_MG_MAIN;
      sub_cnt          <= LD_MG_SUB;
      flash            <= 1'b0;
      mode_q           <= MODE_RUN;
      Source           <= 1'b1;
      main_light_state <= LS_GREEN;
      sub_light_state  <= LS_RED;
      MainColor        <= COL_GREEN;
      SubColor         <= COL_RED;
      main_rest_time   <= LD_MG_MAIN;
      sub_rest_time    <= LD_MG_SUB;
    end else begin
      phase    <= phase_nx;
      main_cnt <= main_nx;
      sub_cnt  <= sub_nx;
      flash    <= flash_nx;
      mode_q   <= mode_n;
      Source   <= source_en;

      main_light_state <= main_state(phase_nx);
      sub_light_state  <= sub_state(phase_nx);
      main_rest_time   <= main_nx;
      sub_rest_time    <= sub_nx;
      // Colours track the phase in RUN and PAUSE, so a pause keeps the
      // last running colour without extra storage.
      MainColor <= source_en ? state_color(main_state(phase_nx)) : COL_OFF;
      SubColor  <= source_en ? state_color(sub_state(phase_nx)) : COL_OFF;

      if (mode_n == MODE_ONLINE) begin
        main_light_state <= LS_ONLINE;
        sub_light_state  <= LS_ONLINE;
        main_rest_time   <= '0;
        sub_rest_time    <= '0;
        MainColor        <= (source_en && flash_nx) ? COL_ONLINE : COL_OFF;
        SubColor         <= (source_en && flash_nx) ? COL_ONLINE : COL_OFF;
      end else if (mode_n == MODE_PAUSE) begin
        main_light_state <= LS_PAUSE;
        sub_light_state  <= LS_PAUSE;
      end
    end
  end

  assign MainTime = 16'(main_rest_time);
  assign SubTime  = 16'(sub_rest_time);

endmodule

// File: tb/tb_traffic_light_ctrl.sv
module tb_traffic_light_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode;
  logic       source_en;

  // Small instance (2 clk/tick, 4/3/2 s) carries the sequencing checks;
  // the default instance is checked against its reset values.
  logic       src_a, src_b;
  logic [2:0] mls_a, sls_a, mls_b, sls_b;
  logic [7:0] mc_a, sc_a, mc_b, sc_b;
  logic [4:0] mr_a, sr_a, mr_b, sr_b;
  logic [15:0] mt_a, st_a, mt_b, st_b;

  traffic_light_ctrl #(
    .CLOCK_HZ(2), .MAIN_GREEN_T(4), .SUB_GREEN_T(3), .YELLOW_T(2), .TIME_W(5)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .source_en(source_en), .Source(src_a),
    .main_light_state(mls_a), .sub_light_state(sls_a),
    .MainColor(mc_a), .SubColor(sc_a),
    .main_rest_time(mr_a), .sub_rest_time(sr_a),
    .MainTime(mt_a), .SubTime(st_a)
  );

  traffic_light_ctrl dut_def (
    .clk(clk), .rst(rst), .mode(mode), .source_en(source_en), .Source(src_b),
    .main_light_state(mls_b), .sub_light_state(sls_b),
    .MainColor(mc_b), .SubColor(sc_b),
    .main_rest_time(mr_b), .sub_rest_time(sr_b),
    .MainTime(mt_b), .SubTime(st_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    bit          def;
    string       name;
    logic [64:0] v;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_run = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Hand-computed RUN sequence for 4/3/2 s, indexed by ticks since MG_SR.
  int t_main [11] = '{4, 3, 2, 1, 2, 1, 5, 4, 3, 2, 1};
  int t_sub  [11] = '{6, 5, 4, 3, 2, 1, 3, 2, 1, 2, 1};
  int t_ph   [11] = '{0, 0, 0, 0, 1, 1, 2, 2, 2, 3, 3};
  int ph_mls [4]  = '{1, 2, 0, 0};
  int ph_sls [4]  = '{0, 0, 1, 2};
  int ph_mc  [4]  = '{2, 3, 1, 1};
  int ph_sc  [4]  = '{1, 1, 2, 3};

  int t = 0;
  int pc = 0;
  bit flash = 0;
  logic [1:0] mq = 2'd0;

  // Monitor: compare every expectation due at this cycle.
  always @(negedge clk) begin
    logic [64:0] obs;
    while (q.size() > 0 && q[0].cyc == cyc) begin
      exp_t e;
      e = q.pop_front();
      obs = e.def ? {mls_b, sls_b, mc_b, sc_b, mr_b, sr_b, src_b, mt_b, st_b}
                  : {mls_a, sls_a, mc_a, sc_a, mr_a, sr_a, src_a, mt_a, st_a};
      n_run++;
      if (obs !== e.v) begin
        n_fail++;
        $display("FAIL %s cyc=%0d got=%h exp=%h", e.name, cyc, obs, e.v);
      end
    end
  end

  function automatic logic [64:0] pack(int ms, int ss, int mc, int sc, int mr, int sr, bit s);
    return {3'(ms), 3'(ss), 8'(mc), 8'(sc), 5'(mr), 5'(sr), s, 16'(mr), 16'(sr)};
  endfunction

  // Inputs are already set; push what the next posedge must produce, then
  // advance to the following negedge.
  task automatic cycle_exp(input string nm);
    exp_t e;
    logic [1:0] m;
    int ph, ms, ss, mc, sc, mr, sr;
    bit s;
    m = 2'd0;
    if (rst) begin
      t = 0; pc = 0; flash = 0; mq = 2'd0;
      e.cyc = cyc + 1; e.def = 1'b1; e.name = {nm, "_def"};
      e.v = pack(1, 0, 2, 1, 16, 19, 1'b1);
      q.push_back(e);
    end else begin
      m = (mode == 2'd3) ? 2'd1 : mode;
      if (m != mq) begin
        if (mq == 2'd2) begin t = 0; pc = 0; end
        if (m == 2'd2) flash = 1;
      end else if (m != 2'd1) begin
        if (pc == 1) begin
          pc = 0;
          if (m == 2'd0) t = (t + 1) % 11;
          else flash = !flash;
        end else begin
          pc = 1;
        end
      end
      mq = m;
    end
    ph = t_ph[t];
    ms = ph_mls[ph]; ss = ph_sls[ph];
    mc = ph_mc[ph];  sc = ph_sc[ph];
    mr = t_main[t];  sr = t_sub[t];
    s  = 1'b1;
    if (!rst) begin
      s = source_en;
      if (!source_en) begin mc = 0; sc = 0; end
      if (m == 2'd1) begin ms = 4; ss = 4; end
      if (m == 2'd2) begin
        ms = 3; ss = 3; mr = 0; sr = 0;
        mc = (source_en && flash) ? 4 : 0;
        sc = mc;
      end
    end
    e.cyc = cyc + 1; e.def = 1'b0; e.name = nm;
    e.v = pack(ms, ss, mc, sc, mr, sr, s);
    q.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; mode = 2'd0; source_en = 1'b1;
    @(negedge clk);
    repeat (2) cycle_exp("reset");
    rst = 1'b0;
    repeat (31) cycle_exp("run");
    mode = 2'd1;
    repeat (10) cycle_exp("pause_my_sr");
    mode = 2'd0;
    repeat (2) cycle_exp("resume");
    mode = 2'd2;
    repeat (9) cycle_exp("online");
    mode = 2'd0;
    repeat (14) cycle_exp("online_to_run");
    mode = 2'd2;
    repeat (3) cycle_exp("online_mr_sg");
    rst = 1'b1;
    cycle_exp("rst_in_online");
    rst = 1'b0;
    cycle_exp("online_after_rst");
    mode = 2'd1;
    repeat (3) cycle_exp("online_to_pause");
    mode = 2'd0;
    repeat (6) cycle_exp("run3");
    source_en = 1'b0;
    repeat (6) cycle_exp("src_off");
    source_en = 1'b1;
    repeat (4) cycle_exp("src_on");
    mode = 2'd3;
    repeat (3) cycle_exp("mode3");
    mode = 2'd0;
    repeat (3) cycle_exp("run_end");
    repeat (2) @(negedge clk);
    n_run++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL pending got=%0d exp=0 expectations left", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
